// File: rtl/sfilt_pkg.sv
// Shared constants and types for the serial-filter command sequencer.
// Holds the command codes, the FSM state enumeration and the config address map.
package sfilt_pkg;

  localparam logic [1:0] CMD_FIRST = 2'd0;
  localparam logic [1:0] CMD_MAC   = 2'd1;
  localparam logic [1:0] CMD_SHIFT = 2'd2;
  localparam logic [1:0] CMD_OUT   = 2'd3;

  localparam logic [4:0] ADDR_NTAPS = 5'd16;
  localparam logic [4:0] ADDR_SHIFT = 5'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_MAC,
    ST_SHIFT,
    ST_OUT
  } state_t;

  // A tap count of zero is meaningless, so it becomes one; anything too large saturates.
  function automatic int unsigned clamp_ntaps(input logic [4:0] v, input int unsigned nmax);
    if (v == 5'd0) return 1;
    if ({27'd0, v} > nmax) return nmax;
    return {27'd0, v};
  endfunction

endpackage

// File: rtl/sfilt_tapmem.sv
// Sample delay line and coefficient store: two register files with one write
// port each and a combinational read by address.
module sfilt_tapmem #(
  parameter int NTAPS_MAX = 16,
  parameter int AW        = $clog2(NTAPS_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x_we,
  input  logic [AW-1:0] x_waddr,
  input  logic [31:0]   x_wdata,
  input  logic [AW-1:0] x_raddr,
  output logic [31:0]   x_rdata,
  input  logic          c_we,
  input  logic [AW-1:0] c_waddr,
  input  logic [31:0]   c_wdata,
  input  logic [AW-1:0] c_raddr,
  output logic [31:0]   c_rdata
);

  logic [31:0] x_mem [NTAPS_MAX];
  logic [31:0] c_mem [NTAPS_MAX];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS_MAX; i++) x_mem[i] <= '0;
    end else if (x_we) begin
      x_mem[x_waddr] <= x_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS_MAX; i++) c_mem[i] <= '0;
    end else if (c_we) begin
      c_mem[c_waddr] <= c_wdata;
    end
  end

  assign x_rdata = x_mem[x_raddr];
  assign c_rdata = c_mem[c_raddr];

endmodule

// File: rtl/sfilt_seq.sv
// Command sequencer for a serial FIR datapath: accepts one sample, then issues
// first-mult, MACs, shift+round and output commands back-to-back.
module sfilt_seq
  import sfilt_pkg::*;
#(
  parameter int NTAPS_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        busy,
  output logic        f_pushin,
  output logic [1:0]  f_cmd,
  output logic [31:0] f_q,
  output logic [31:0] f_h
);

  localparam int AW = $clog2(NTAPS_MAX);
  localparam int NW = AW + 1;

  state_t        state;
  logic [AW-1:0] wp;
  logic [AW-1:0] base;
  logic [AW-1:0] tap;
  logic [AW-1:0] rd_tap;
  logic [AW-1:0] x_raddr;
  logic [NW-1:0] ntaps;
  logic [6:0]    shift;
  logic [31:0]   x_rdata;
  logic [31:0]   c_rdata;
  logic [31:0]   c0;
  logic          xfer;
  logic          cfg_ok;
  logic          c_we;
  logic          last_tap;

  assign s_ready  = (state == ST_IDLE) || (state == ST_OUT);
  assign busy     = (state != ST_IDLE);
  assign xfer     = s_valid && s_ready;
  assign cfg_ok   = cfg_we && !busy;
  assign c_we     = cfg_ok && (int'({27'd0, cfg_addr}) < NTAPS_MAX);

  // Look one tap ahead so the registered outputs hold the operands for the current state.
  assign rd_tap   = s_ready ? '0 : tap + AW'(1);
  assign x_raddr  = base - rd_tap;
  assign last_tap = ({1'b0, tap} == ntaps - NW'(1));

  // A coefficient write in the same cycle as the transfer must reach the FIRST command.
  assign c0 = (cfg_ok && cfg_addr == 5'd0) ? cfg_wdata : c_rdata;

  sfilt_tapmem #(.NTAPS_MAX(NTAPS_MAX), .AW(AW)) u_tapmem (
    .clk     (clk),
    .rst     (rst),
    .x_we    (xfer),
    .x_waddr (wp),
    .x_wdata (s_data),
    .x_raddr (x_raddr),
    .x_rdata (x_rdata),
    .c_we    (c_we),
    .c_waddr (AW'(cfg_addr)),
    .c_wdata (cfg_wdata),
    .c_raddr (rd_tap),
    .c_rdata (c_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      wp       <= '0;
      base     <= '0;
      tap      <= '0;
      ntaps    <= NW'(1);
      shift    <= '0;
      f_pushin <= 1'b0;
      f_cmd    <= '0;
      f_q      <= '0;
      f_h      <= '0;
    end else begin
      if (cfg_ok && cfg_addr == ADDR_NTAPS)
        ntaps <= NW'(clamp_ntaps(cfg_wdata[4:0], NTAPS_MAX));
      if (cfg_ok && cfg_addr == ADDR_SHIFT)
        shift <= cfg_wdata[6:0];
      if (xfer) begin
        wp   <= wp + AW'(1);
        base <= wp;
      end

      case (state)
        ST_IDLE, ST_OUT: begin
          if (xfer) begin
            state    <= ST_FIRST;
            tap      <= '0;
            f_pushin <= 1'b1;
            f_cmd    <= CMD_FIRST;
            f_q      <= s_data;
            f_h      <= c0;
          end else begin
            state    <= ST_IDLE;
            f_pushin <= 1'b0;
            f_cmd    <= '0;
            f_q      <= '0;
            f_h      <= '0;
          end
        end
        ST_FIRST, ST_MAC: begin
          f_pushin <= 1'b1;
          if (last_tap) begin
            state <= ST_SHIFT;
            f_cmd <= CMD_SHIFT;
            f_q   <= '0;
            f_h   <= {25'd0, shift};
          end else begin
            state <= ST_MAC;
            tap   <= rd_tap;
            f_cmd <= CMD_MAC;
            f_q   <= x_rdata;
            f_h   <= c_rdata;
          end
        end
        ST_SHIFT: begin
          state    <= ST_OUT;
          f_pushin <= 1'b1;
          f_cmd    <= CMD_OUT;
          f_q      <= '0;
          f_h      <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          f_pushin <= 1'b0;
          f_cmd    <= '0;
          f_q      <= '0;
          f_h      <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/sfilt_seq.md
SFILT_SEQ -- requirements
Module: sfilt_seq

Interface
REQ-001 SHALL have parameter NTAPS_MAX, default 16, giving the maximum number of filter taps (power of 2).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port s_valid  in  1  input sample offered.
REQ-005 SHALL have port s_data  in  32  signed input sample.
REQ-006 SHALL have port s_ready  out  1  sequencer accepts a sample this cycle.
REQ-007 SHALL have port cfg_we  in  1  configuration write strobe.
REQ-008 SHALL have port cfg_addr  in  5  config address: 0..NTAPS_MAX-1 = coefficient, 16 = ntaps, 17 = shift.
REQ-009 SHALL have port cfg_wdata  in  32  configuration write data.
REQ-010 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL have port f_pushin  out  1  command valid to the serial filter.
REQ-012 SHALL have port f_cmd  out  2  filter command: 0 first mult, 1 MAC, 2 shift+round, 3 output+clear.
REQ-013 SHALL have port f_q  out  32  sample operand.
REQ-014 SHALL have port f_h  out  32  coefficient operand, or shift amount in bits [6:0] for cmd 2.

Function
REQ-015 Handshake: a sample SHALL transfer on a cycle where s_valid and s_ready are both high.
REQ-016 s_ready SHALL be high in IDLE and in OUT, and low in every other state.
REQ-017 The FSM SHALL have five states, IDLE, FIRST, MAC, SHIFT and OUT, with these transitions:
- IDLE -> FIRST on a transfer.
- FIRST -> MAC if ntaps > 1, else FIRST -> SHIFT.
- MAC -> SHIFT after tap index ntaps-1.
- SHIFT -> OUT.
- OUT -> FIRST on a transfer, else OUT -> IDLE.
REQ-018 On a transfer, s_data SHALL be written to the delay line at pointer wp, and wp SHALL then increment modulo NTAPS_MAX.
REQ-019 Tap k SHALL use sample x[(wp_at_accept - k) mod NTAPS_MAX], where wp_at_accept is the slot just written, with coefficient c[k].
REQ-020 Registered outputs SHALL present exactly one command per cycle, f_pushin=1, in each non-IDLE state:
- FIRST: f_cmd=0, f_q=x(tap 0), f_h=c[0].
- MAC: f_cmd=1, tap k = 1..ntaps-1.
- SHIFT: f_cmd=2, f_q=0, f_h={25'b0,shift}.
- OUT: f_cmd=3, f_q=0, f_h=0.
REQ-021 f_pushin SHALL be 0 in IDLE; f_cmd, f_q and f_h SHALL hold 0 whenever f_pushin=0.
REQ-022 The first command SHALL appear on the cycle after the transfer; each sample SHALL issue exactly ntaps+2 commands, back-to-back.
REQ-023 The sequencer SHALL sustain one sample per ntaps+2 cycles, with no bubble when the next sample is accepted in OUT.
REQ-024 ntaps SHALL be taken from cfg_wdata[4:0]; a written 0 SHALL be stored as 1, and values above NTAPS_MAX SHALL be stored as NTAPS_MAX.
REQ-025 shift SHALL be taken from cfg_wdata[6:0].
REQ-026 Config writes SHALL take effect only when busy=0; writes with busy=1 SHALL be dropped with no state change.
REQ-027 Writes to cfg_addr values 18..31 SHALL be ignored.
REQ-028 ntaps, shift and the coefficients SHALL be sampled at the transfer and held for that sample's whole sequence.
REQ-029 A simultaneous cfg_we and transfer in IDLE SHALL apply the config write first, so the new value is used for that sample.
REQ-030 The delay line SHALL wrap; history beyond NTAPS_MAX samples SHALL be overwritten.

Reset
REQ-031 On reset assertion (rst=0), the state SHALL return to IDLE asynchronously, abandoning any in-flight sequence; the downstream accumulator is not cleared by this block.
REQ-032 Reset values SHALL be: s_ready=1 (after reset deasserts), busy=0, f_pushin=0, f_cmd=0, f_q=0, f_h=0, wp=0, all delay-line samples 0, all coefficients 0, ntaps=1, shift=0.
REQ-033 Reset deassertion SHALL be followed by normal operation on the next rising clk edge.

Structure
REQ-034 A shared package SHALL hold the command-code constants (CMD_FIRST=0, CMD_MAC=1, CMD_SHIFT=2, CMD_OUT=3), the FSM state enumeration, and the config address constants (ADDR_NTAPS=16, ADDR_SHIFT=17).
REQ-035 The delay line and coefficient store SHALL be one sub-module, sfilt_tapmem: two NTAPS_MAX x 32 register files with one write port each and a combinational read by tap index.
REQ-036 The FSM, tap counter and config registers SHALL reside in sfilt_seq.

Verification
REQ-037 Scenario, 3 taps: ntaps=3, c={2,3,4}, shift=1; push samples 10 then 20 -> commands per sample:
- sample 10: (0,10,2),(1,0,3),(1,0,4),(2,0,1),(3,0,0).
- sample 20: (0,20,2),(1,10,3),(1,0,4),(2,0,1),(3,0,0).
REQ-038 Scenario, single tap: ntaps=1 -> each sample issues exactly 3 commands (cmd 0, 2, 3).
REQ-039 Scenario, back-to-back: s_valid held high with ntaps=4 -> f_pushin stays 1 continuously, and s_ready pulses once every 6 cycles.
REQ-040 Scenario, config while busy: cfg write c[0]=99 while busy=1 -> dropped, c[0] unchanged; the same write at IDLE together with a transfer -> f_h=99 on FIRST.
REQ-041 Scenario, clamping and wrap: ntaps written 0 -> stored 1; ntaps written 31 -> stored 16; 17 samples pushed with ntaps=16 -> the oldest sample is overwritten by wrap-around.
REQ-042 Scenario, reset mid-sequence: rst=0 during MAC -> f_pushin=0 immediately and all registers at reset values; the next transfer after reset starts at FIRST with zeroed history.
